divider_iter: RTL and testbench

- Multi-cycle iterative integer divider for the execute stage; the inverse arithmetic unit to the pipelined multiplier.
- Implements RV64 DIV/DIVU/REM/REMU semantics using radix-2 restoring division, one quotient bit per cycle.
- The execute stage starts an operation with a start pulse, stalls while busy is high, and captures q/r when done pulses.

---
 rtl/divider_iter_if.sv | 25 ++
 rtl/divider_iter.sv | 135 +++++++++++++
 tb/tb_divider_iter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/divider_iter_if.sv
// rtl/divider_iter_if.sv - execute-stage handshake bundle for the iterative divider
interface divider_iter_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    modport master (
        output start, a, b, is_signed, flush,
        input  ready, busy, done, q, r
    );

    modport slave (
        input  start, a, b, is_signed, flush,
        output ready, busy, done, q, r
    );
endinterface

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - radix-2 restoring divider with RV64 DIV/DIVU/REM/REMU semantics
module divider_iter #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    divider_iter_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             ovf;
    logic             accept;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // Operand magnitudes and the special cases resolved at the accept edge
    always_comb begin
        a_neg    = bus.is_signed & bus.a[WIDTH-1];
        b_neg    = bus.is_signed & bus.b[WIDTH-1];
        a_abs    = a_neg ? -bus.a : bus.a;
        b_abs    = b_neg ? -bus.b : bus.b;
        div_zero = (bus.b == '0);
        ovf      = bus.is_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
        accept   = bus.start & ready_r & ~bus.flush;
    end

    // One restoring step; the borrow out of the WIDTH+1 bit subtract is the compare
    always_comb begin
        rem_sh  = {rem, quo[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs};
        quo_nxt = {quo[WIDTH-2:0], 1'b0};
        rem_nxt = rem_sh[WIDTH-1:0];
        if (!diff[WIDTH]) begin
            rem_nxt    = diff[WIDTH-1:0];
            quo_nxt[0] = 1'b1;
        end
    end

    // Control FSM, datapath registers and registered results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            q_r     <= '0;
            r_r     <= '0;
        end else if (bus.flush) begin
            state   <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        q_r     <= neg_q ? -quo_nxt : quo_nxt;
                        r_r     <= neg_r ? -rem_nxt : rem_nxt;
                        state   <= DONE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    if (accept) begin
                        if (div_zero) begin
                            q_r    <= '1;
                            r_r    <= bus.a;
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else if (ovf) begin
                            q_r    <= bus.a;
                            r_r    <= '0;
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            rem     <= '0;
                            quo     <= a_abs;
                            dvs     <= b_abs;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            cnt     <= '0;
                            state   <= BUSY;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.q     = q_r;
    assign bus.r     = r_r;
endmodule

// File: tb/tb_divider_iter.sv
// tb/tb_divider_iter.sv - scoreboard bench for the iterative divider
module tb_divider_iter;
    localparam int W = 64;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           acc;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    divider_iter_if #(.WIDTH(W)) dif ();

    divider_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    // Cycle stamp used to measure accept-to-done latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, expv);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (dif.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("q", dif.q, e.q);
                chk("r", dif.r, e.r);
                chk("latency", W'(cyc - e.acc), W'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accept edge
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input int lat,
                         input bit push);
        exp_t e;
        dif.a         = ta;
        dif.b         = tb_v;
        dif.is_signed = ts;
        dif.start     = 1'b1;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.acc = cyc + 1;
            e.lat = lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        dif.start = 1'b0;
    endtask

    task automatic wait_done(input int busy_exp);
        int nb = 0;
        int n  = 0;
        while (dif.done !== 1'b1 && n < 200) begin
            if (dif.ready === 1'b0 && dif.busy === 1'b1) nb++;
            n++;
            @(negedge clk);
        end
        if (dif.done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done in %0d cycles required done", n);
        end else begin
            chk("busy_cycles", W'(nb), W'(busy_exp));
            @(negedge clk);
            chk("done_width", W'(dif.done), W'(0));
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input int lat);
        issue(ta, tb_v, ts, eq, er, lat, 1'b1);
        wait_done(lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.start     = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.is_signed = 1'b0;
        dif.flush     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", W'(dif.ready), W'(1));
        chk("rst_busy", W'(dif.busy), W'(0));
        chk("rst_done", W'(dif.done), W'(0));
        chk("rst_q", dif.q, '0);
        chk("rst_r", dif.r, '0);
        reset = 1'b0;
        @(negedge clk);

        run_op(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 64);
        run_op(-64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run_op(64'd7, -64'sd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 64);
        run_op(64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 0);
        run_op(64'h1234, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 0);
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'h8000_0000_0000_0000, 64'd0, 0);
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               64'd0, 64'h8000_0000_0000_0000, 64);

        // Flush in BUSY cycle 30: results must stay at the previous operation
        issue(64'd1000, 64'd7, 1'b0, '0, '0, 0, 1'b0);
        repeat (29) @(negedge clk);
        dif.flush = 1'b1;
        @(negedge clk);
        dif.flush = 1'b0;
        chk("flush_ready", W'(dif.ready), W'(1));
        chk("flush_done", W'(dif.done), W'(0));
        chk("flush_q_hold", dif.q, 64'd0);
        chk("flush_r_hold", dif.r, 64'h8000_0000_0000_0000);
        run_op(64'd9, 64'd3, 1'b0, 64'd3, 64'd0, 64);

        // A start pulse while BUSY is ignored
        issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 64, 1'b1);
        repeat (10) @(negedge clk);
        dif.a     = 64'd5;
        dif.b     = 64'd1;
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        wait_done(53);

        // Back-to-back: start held high, new operands presented in the DONE cycle
        issue(64'd50, 64'd3, 1'b0, 64'd16, 64'd2, 64, 1'b1);
        dif.start = 1'b1;
        for (int i = 0; i < 200 && dif.done !== 1'b1; i++) @(negedge clk);
        issue(64'd1000, 64'd10, 1'b0, 64'd100, 64'd0, 64, 1'b1);
        wait_done(64);

        // Asynchronous reset mid-BUSY takes effect between clock edges
        issue(64'd123, 64'd4, 1'b0, '0, '0, 0, 1'b0);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", W'(dif.busy), W'(0));
        chk("arst_ready", W'(dif.ready), W'(1));
        chk("arst_done", W'(dif.done), W'(0));
        chk("arst_q", dif.q, '0);
        chk("arst_r", dif.r, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Zero dividend still takes the full iteration count
        run_op(64'd0, 64'd5, 1'b1, 64'd0, 64'd0, 64);

        repeat (5) @(negedge clk);
        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
